nios_cpu_debug_host_shifter: RTL and testbench

- Initiator side of the CPU debug-slave virtual-JTAG link. It generates the ir_in, state-strobe, tck and tdi sequence that the debug slave consumes, and captures tdo.
- Lets in-fabric logic or a system bench issue debug commands (instruction register value plus a 38-bit data register word) without a physical JTAG cable.
- Each command runs one complete UIR -> CDR -> SDR -> UDR transaction and returns the data shifted out on tdo.

---
 rtl/nios_cpu_debug_host_shifter.sv | 170 +++++++++++++++++
 tb/tb_nios_cpu_debug_host_shifter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_cpu_debug_host_shifter.sv
// nios_cpu_debug_host_shifter: initiator side of the CPU debug-slave virtual-JTAG link.
// Each accepted command runs one UIR -> CDR -> SDR -> UDR transaction. The transaction
// shifts cmd_data in LSB first and returns the tdo bits captured during SDR.
// Optional feature: define NIOS_DEBUG_HOST_IR_CACHE_EN to skip UIR when the IR is unchanged.
module nios_cpu_debug_host_shifter #(
    parameter int unsigned DR_WIDTH = 38,
    parameter int unsigned IR_WIDTH = 2,
    parameter int unsigned TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_rti,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr
);

    localparam int unsigned BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam int unsigned DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DR_WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(TCK_DIV - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_UIR  = 3'd1;
    localparam logic [2:0] ST_CDR  = 3'd2;
    localparam logic [2:0] ST_SDR  = 3'd3;
    localparam logic [2:0] ST_UDR  = 3'd4;
    // Trailing state: its falling-tck event closes the UDR period and raises rsp_valid.
    localparam logic [2:0] ST_END  = 3'd5;
    localparam logic [2:0] ST_RESP = 3'd6;

    logic [2:0]          state;
    logic [DW-1:0]       div_cnt;
    logic                rise_next;   // next tck event drives tck high
    logic [BW-1:0]       bit_cnt;
    logic [DR_WIDTH-1:0] data_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic                tick;
    logic                skip_uir;
    logic [DR_WIDTH:0]   cap_shift;

    assign cmd_ready = (state == ST_IDLE);
    assign tick      = (div_cnt == DIV_LAST);
    // New tdo bit enters at the top; after DR_WIDTH shifts the first sample sits at bit 0.
    assign cap_shift = {vji_tdo, rsp_data};

`ifdef NIOS_DEBUG_HOST_IR_CACHE_EN
    logic                cache_valid;
    logic [IR_WIDTH-1:0] cache_ir;

    // Remember the IR of the last accepted command.
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid <= 1'b0;
            cache_ir    <= '0;
        end else if (state == ST_IDLE && cmd_valid) begin
            cache_valid <= 1'b1;
            cache_ir    <= cmd_ir;
        end
    end

    assign skip_uir = cache_valid && (cmd_ir == cache_ir);
`else
    assign skip_uir = 1'b0;
`endif

    // Transaction sequencer: tck divider, strobes, serial shift and response handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            rise_next  <= 1'b0;
            bit_cnt    <= '0;
            data_q     <= '0;
            ir_q       <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_ir_out <= '0;
            vji_tck    <= 1'b0;
            vji_tdi    <= 1'b0;
            vji_ir_in  <= '0;
            vji_rti    <= 1'b1;
            vji_uir    <= 1'b0;
            vji_cdr    <= 1'b0;
            vji_sdr    <= 1'b0;
            vji_udr    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        data_q    <= cmd_data;
                        ir_q      <= cmd_ir;
                        // Preload so the very next edge is the first falling-tck event.
                        div_cnt   <= DIV_LAST;
                        rise_next <= 1'b0;
                        state     <= skip_uir ? ST_CDR : ST_UIR;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    if (!tick) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt   <= '0;
                        rise_next <= !rise_next;
                        if (!rise_next) begin
                            // Falling event: start of a tck period for the current state.
                            vji_tck <= 1'b0;
                            vji_uir <= (state == ST_UIR);
                            vji_cdr <= (state == ST_CDR);
                            vji_sdr <= (state == ST_SDR);
                            vji_udr <= (state == ST_UDR);
                            vji_tdi <= (state == ST_SDR) && data_q[0];
                            vji_rti <= (state == ST_END);
                            if (state == ST_UIR) begin
                                vji_ir_in <= ir_q;
                            end
                            if (state == ST_END) begin
                                rsp_valid <= 1'b1;
                                state     <= ST_RESP;
                            end
                        end else begin
                            // Rising event: sample the slave, then pick the next period.
                            vji_tck <= 1'b1;
                            case (state)
                                ST_UIR: state <= ST_CDR;
                                ST_CDR: begin
                                    rsp_ir_out <= vji_ir_out;
                                    bit_cnt    <= '0;
                                    state      <= ST_SDR;
                                end
                                ST_SDR: begin
                                    rsp_data <= cap_shift[DR_WIDTH:1];
                                    data_q   <= data_q >> 1;
                                    if (bit_cnt == LAST_BIT) begin
                                        state <= ST_UDR;
                                    end else begin
                                        bit_cnt <= bit_cnt + 1'b1;
                                    end
                                end
                                ST_UDR:  state <= ST_END;
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_cpu_debug_host_shifter.sv
// tb_nios_cpu_debug_host_shifter: directed bench for the virtual-JTAG host shifter.
// dut0 uses default parameters with a slave model; dut1 uses TCK_DIV=1, DR_WIDTH=8.
module tb_nios_cpu_debug_host_shifter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_ir = 2'b00;
    logic [37:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [37:0] rsp_data;
    logic [1:0]  rsp_ir_out;
    logic        vji_tck, vji_tdi, vji_tdo;
    logic [1:0]  vji_ir_in;
    logic [1:0]  vji_ir_out = 2'b00;
    logic        vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr;

    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [1:0]  s_ir = 2'b00;
    logic [7:0]  s_data = '0;
    logic        s_rsp_valid;
    logic        s_rsp_ready = 1'b0;
    logic [7:0]  s_rsp_data;
    logic [1:0]  s_rsp_ir_out;
    logic        s_tck, s_tdi;
    logic        s_tdo = 1'b1;
    logic [1:0]  s_ir_in;
    logic [1:0]  s_ir_out = 2'b01;
    logic        s_rti, s_uir, s_cdr, s_sdr, s_udr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nios_cpu_debug_host_shifter dut0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out), .vji_tck(vji_tck), .vji_tdi(vji_tdi),
        .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out), .vji_rti(vji_rti),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr)
    );

    nios_cpu_debug_host_shifter #(.DR_WIDTH(8), .IR_WIDTH(2), .TCK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid(s_valid), .cmd_ready(s_ready),
        .cmd_ir(s_ir), .cmd_data(s_data), .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
        .rsp_data(s_rsp_data), .rsp_ir_out(s_rsp_ir_out), .vji_tck(s_tck), .vji_tdi(s_tdi),
        .vji_tdo(s_tdo), .vji_ir_in(s_ir_in), .vji_ir_out(s_ir_out), .vji_rti(s_rti),
        .vji_uir(s_uir), .vji_cdr(s_cdr), .vji_sdr(s_sdr), .vji_udr(s_udr)
    );

    // Slave model: tdo presents pattern bit k before the k-th SDR rising tck.
    logic [37:0] pat = 38'h2A_5A5A_5A5A;
    logic [37:0] tdi_cap = '0;
    int sdr_idx = 0;
    int uir_r = 0, cdr_r = 0, sdr_r = 0, udr_r = 0;

    assign vji_tdo = (sdr_idx < 38) ? pat[sdr_idx] : 1'b0;

    always @(posedge vji_tck) begin
        if (vji_uir) uir_r <= uir_r + 1;
        if (vji_cdr) begin
            cdr_r   <= cdr_r + 1;
            sdr_idx <= 0;
        end
        if (vji_sdr) begin
            sdr_r <= sdr_r + 1;
            if (sdr_idx < 38) tdi_cap[sdr_idx] <= vji_tdi;
            sdr_idx <= sdr_idx + 1;
        end
        if (vji_udr) udr_r <= udr_r + 1;
    end

    // Strobe exclusivity, rti and ir_in change monitors.
    int onehot_bad = 0;
    int ir_bad = 0;
    logic [1:0] prev_ir = 2'b00;
    always @(negedge clk) begin
        if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr}) > 1) onehot_bad <= onehot_bad + 1;
        else if (vji_rti && (vji_uir || vji_cdr || vji_sdr || vji_udr))
            onehot_bad <= onehot_bad + 1;
        if (vji_ir_in !== prev_ir && !vji_uir) ir_bad <= ir_bad + 1;
        prev_ir <= vji_ir_in;
    end

    task automatic send_cmd(input logic [1:0] ir, input logic [37:0] d);
        cmd_ir    = ir;
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Returns the number of edges after acceptance until rsp_valid, or -1 on timeout.
    task automatic wait_rsp(output int n);
        n = -1;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: ready=%b valid=%b want 1 0", cmd_ready, rsp_valid);
        end
        checks++;
        if (rsp_data !== 38'h0 || rsp_ir_out !== 2'b00 || vji_ir_in !== 2'b00) begin
            failures++;
            $display("FAIL reset_data: data=%h irout=%b irin=%b want 0", rsp_data, rsp_ir_out,
                     vji_ir_in);
        end
        checks++;
        if ({vji_tck, vji_tdi, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr} !== 7'b0010000) begin
            failures++;
            $display("FAIL reset_jtag: got %b want 0010000",
                     {vji_tck, vji_tdi, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int n;
        int u0, c0, s0, d0;
        logic ok;
        logic [37:0] held;
        u0 = uir_r; c0 = cdr_r; s0 = sdr_r; d0 = udr_r;
        vji_ir_out = 2'b10;
        send_cmd(2'b01, 38'h3F_0000_0001);
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL accept_ready: got %b want 0", cmd_ready);
        end
        wait_rsp(n);
        checks++;
        if (n !== 165) begin failures++; $display("FAIL latency: got %0d want 165", n); end
        checks++;
        if (rsp_data !== pat) begin
            failures++;
            $display("FAIL rsp_data: got %h want %h", rsp_data, pat);
        end
        checks++;
        if (rsp_ir_out !== 2'b10) begin
            failures++;
            $display("FAIL rsp_ir_out: got %b want 10", rsp_ir_out);
        end
        checks++;
        if (tdi_cap[0] !== 1'b1 || tdi_cap !== 38'h3F_0000_0001) begin
            failures++;
            $display("FAIL tdi_bits: got %h want 3f00000001", tdi_cap);
        end
        checks++;
        if (sdr_r - s0 !== 38) begin
            failures++;
            $display("FAIL sdr_rises: got %0d want 38", sdr_r - s0);
        end
        checks++;
        if (uir_r - u0 !== 1 || cdr_r - c0 !== 1 || udr_r - d0 !== 1) begin
            failures++;
            $display("FAIL periods: uir=%0d cdr=%0d udr=%0d want 1 1 1", uir_r - u0, cdr_r - c0,
                     udr_r - d0);
        end
        checks++;
        if (vji_ir_in !== 2'b01 || vji_rti !== 1'b1 || vji_tck !== 1'b0) begin
            failures++;
            $display("FAIL resp_jtag: irin=%b rti=%b tck=%b want 01 1 0", vji_ir_in, vji_rti,
                     vji_tck);
        end
        // Stall the response for 20 cycles; outputs must hold.
        vji_ir_out = 2'b01;
        held = rsp_data;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0 ||
                vji_tck !== 1'b0 || rsp_ir_out !== 2'b10) ok = 1'b0;
        end
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL stall_stable: got %b want 1", ok);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL handshake: valid=%b ready=%b want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int ib;
        ib = ir_bad;
        rsp_ready  = 1'b1;
        vji_ir_out = 2'b11;
        cmd_ir     = 2'b11;
        cmd_data   = 38'h15_5555_AAAA;
        cmd_valid  = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || vji_ir_in !== 2'b01) begin
            failures++;
            $display("FAIL b2b_accept: ready=%b irin=%b want 0 01", cmd_ready, vji_ir_in);
        end
        cmd_ir   = 2'b10;
        cmd_data = 38'h0A_0F0F_F0F0;
        wait_rsp(n);
        checks++;
        if (n !== 165 || tdi_cap !== 38'h15_5555_AAAA || vji_ir_in !== 2'b11) begin
            failures++;
            $display("FAIL b2b_first: lat=%0d tdi=%h irin=%b want 165 155555aaaa 11", n,
                     tdi_cap, vji_ir_in);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_pulse: valid=%b ready=%b want 0 1", rsp_valid, cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_accept: ready=%b want 0", cmd_ready);
        end
        cmd_valid = 1'b0;
        wait_rsp(n);
        checks++;
        if (n !== 165 || tdi_cap !== 38'h0A_0F0F_F0F0 || rsp_data !== pat ||
            rsp_ir_out !== 2'b11) begin
            failures++;
            $display("FAIL b2b_second: lat=%0d tdi=%h data=%h irout=%b want 165 0a0f0ff0f0", n,
                     tdi_cap, rsp_data, rsp_ir_out);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (vji_ir_in !== 2'b10 || ir_bad - ib !== 0) begin
            failures++;
            $display("FAIL b2b_ir_in: irin=%b stray_changes=%0d want 10 0", vji_ir_in,
                     ir_bad - ib);
        end
    endtask

    task automatic test_reset_mid;
        logic found;
        logic saw_valid, saw_busy;
        int d0;
        found = 1'b0;
        send_cmd(2'b01, 38'h0);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (vji_sdr === 1'b1 && sdr_idx == 17) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1) begin
            failures++;
            $display("FAIL reach_bit17: got %b want 1", found);
        end
        d0 = udr_r;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_rti, vji_uir, vji_cdr, vji_sdr,
             vji_udr} !== 9'b100010000 || vji_ir_in !== 2'b00 || rsp_data !== 38'h0 ||
            rsp_ir_out !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset: flags=%b irin=%b data=%h want 100010000 00 0",
                     {cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_rti, vji_uir, vji_cdr,
                      vji_sdr, vji_udr}, vji_ir_in, rsp_data);
        end
        reset = 1'b0;
        saw_valid = 1'b0;
        saw_busy  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) saw_valid = 1'b1;
            if (cmd_ready !== 1'b1) saw_busy = 1'b1;
        end
        checks++;
        if (saw_valid || saw_busy || udr_r != d0) begin
            failures++;
            $display("FAIL post_abort: valid=%b busy=%b udr=%0d want 0 0 0", saw_valid,
                     saw_busy, udr_r - d0);
        end
    endtask

    task automatic test_small;
        int n, r1, r2;
        logic prev;
        n = -1; r1 = -1; r2 = -1;
        prev = s_tck;
        s_ir    = 2'b11;
        s_data  = 8'hA5;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (prev === 1'b0 && s_tck === 1'b1) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
            prev = s_tck;
            if (s_rsp_valid) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n !== 23) begin failures++; $display("FAIL small_latency: got %0d want 23", n); end
        checks++;
        if (r1 !== 2 || r2 - r1 !== 2) begin
            failures++;
            $display("FAIL small_tck: first=%0d period=%0d want 2 2", r1, r2 - r1);
        end
        checks++;
        if (s_rsp_data !== 8'hFF || s_rsp_ir_out !== 2'b01 || s_ir_in !== 2'b11) begin
            failures++;
            $display("FAIL small_data: data=%h irout=%b irin=%b want ff 01 11", s_rsp_data,
                     s_rsp_ir_out, s_ir_in);
        end
        s_rsp_ready = 1'b1;
        @(negedge clk);
        s_rsp_ready = 1'b0;
        checks++;
        if (s_rsp_valid !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL small_hs: valid=%b ready=%b want 0 1", s_rsp_valid, s_ready);
        end
    endtask

`ifdef NIOS_DEBUG_HOST_IR_CACHE_EN
    task automatic test_ir_cache;
        logic [1:0] irs [3] = '{2'b10, 2'b10, 2'b00};
        int lat [3] = '{165, 161, 165};
        int ups [3] = '{1, 0, 1};
        int n, u0;
        for (int k = 0; k < 3; k++) begin
            u0 = uir_r;
            send_cmd(irs[k], 38'h1);
            wait_rsp(n);
            checks++;
            if (n !== lat[k] || uir_r - u0 !== ups[k] || vji_ir_in !== irs[k]) begin
                failures++;
                $display("FAIL ir_cache_%0d: lat=%0d uir=%0d irin=%b want %0d %0d %b", k, n,
                         uir_r - u0, vji_ir_in, lat[k], ups[k], irs[k]);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid();
        test_small();
`ifdef NIOS_DEBUG_HOST_IR_CACHE_EN
        test_ir_cache();
`endif
        checks++;
        if (onehot_bad !== 0) begin
            failures++;
            $display("FAIL strobe_onehot: violations=%0d want 0", onehot_bad);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
